// File: rtl/scan_ctr_if.sv
// rtl/scan_ctr_if.sv - scan-chain front end for the 16-bit control register
//
// Purpose:
//   Deserialises framed scan traffic [op][data MSB..LSB] into single-cycle
//   register writes (op=1) or handshaked register reads (op=0). Read data is
//   parked in a readback shift register and streamed out on scan_out while
//   the host shifts in its next frame.
//
// Configuration:
//   SCAN_PARITY_EN - when defined, each frame carries a trailing even-parity
//                    bit over op+data and FRAME_LEN becomes DATA_W+2.
//
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   scan_en        - frame enable; its falling edge closes the frame
//   scan_in        - serial frame data, op bit first then data MSB first
//   scan_out       - MSB of the readback shift register
//   ctr_wdata      - write data, held until the next write
//   ctr_wen        - one-cycle write strobe
//   ctr_ren        - read request, held until ctr_ready or timeout
//   ctr_rdata      - read data from the control register
//   ctr_ready      - read handshake from the control register
//   busy           - high while a register access is in progress
//   frame_err      - sticky: last frame had a bad length or parity
//   rd_to          - sticky: last read timed out

module scan_ctr_if #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    output logic [DATA_W-1:0] ctr_wdata,
    output logic              ctr_wen,
    output logic              ctr_ren,
    input  logic [DATA_W-1:0] ctr_rdata,
    input  logic              ctr_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              rd_to
);

`ifdef SCAN_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 2;
`else
    localparam int FRAME_LEN = DATA_W + 1;
`endif

    // bit_cnt must hold FRAME_LEN+1, the saturating overflow marker.
    localparam int CNT_W  = $clog2(FRAME_LEN + 2);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LEN   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_OVF   = CNT_W'(FRAME_LEN + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT     = 2'd1,
        ST_WRITE     = 2'd2,
        ST_READ_WAIT = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [FRAME_LEN-1:0] in_sr_q,    in_sr_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [DATA_W-1:0]   out_sr_q,    out_sr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                wen_q,       wen_d;
    logic                ren_q,       ren_d;
    logic                busy_q,      busy_d;
    logic                frame_err_q, frame_err_d;
    logic                rd_to_q,     rd_to_d;

    // Frame fields as they sit in in_sr once the last bit has been taken.
    logic              frame_op;
    logic [DATA_W-1:0] frame_data;
    logic              parity_bad;

`ifdef SCAN_PARITY_EN
    assign frame_op   = in_sr_q[FRAME_LEN-1];
    assign frame_data = in_sr_q[DATA_W:1];
    // Even parity: op, data and parity bit together must XOR to zero.
    assign parity_bad = ^in_sr_q;
`else
    assign frame_op   = in_sr_q[FRAME_LEN-1];
    assign frame_data = in_sr_q[DATA_W-1:0];
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        in_sr_d     = in_sr_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        out_sr_d    = out_sr_q;
        wdata_d     = wdata_q;
        frame_err_d = frame_err_q;
        rd_to_d     = rd_to_q;

        case (state_q)
            ST_IDLE: begin
                if (scan_en) begin
                    // First bit of a new frame: status from the previous
                    // frame is dropped and readback starts streaming.
                    in_sr_d     = {in_sr_q[FRAME_LEN-2:0], scan_in};
                    out_sr_d    = {out_sr_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d   = CNT_ONE;
                    frame_err_d = 1'b0;
                    rd_to_d     = 1'b0;
                    state_d     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (scan_en) begin
                    in_sr_d  = {in_sr_q[FRAME_LEN-2:0], scan_in};
                    out_sr_d = {out_sr_q[DATA_W-2:0], 1'b0};
                    // Saturate so an arbitrarily long frame can never wrap
                    // back onto a legal length.
                    if (bit_cnt_q != CNT_OVF) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if ((bit_cnt_q == CNT_LEN) && !parity_bad) begin
                    if (frame_op) begin
                        wdata_d = frame_data;
                        state_d = ST_WRITE;
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = ST_READ_WAIT;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
            end

            ST_READ_WAIT: begin
                // A ready arriving on the last permitted cycle still wins
                // over the timeout.
                if (ctr_ready) begin
                    out_sr_d = ctr_rdata;
                    state_d  = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    out_sr_d = '0;
                    rd_to_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered off the next state so they leave the block
        // glitch-free and line up exactly with the WRITE / READ_WAIT cycles.
        wen_d  = (state_d == ST_WRITE);
        ren_d  = (state_d == ST_READ_WAIT);
        busy_d = wen_d | ren_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_sr_q     <= '0;
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            out_sr_q    <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            rd_to_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_sr_q     <= in_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            out_sr_q    <= out_sr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            rd_to_q     <= rd_to_d;
        end
    end

    assign scan_out  = out_sr_q[DATA_W-1];
    assign ctr_wdata = wdata_q;
    assign ctr_wen   = wen_q;
    assign ctr_ren   = ren_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign rd_to     = rd_to_q;

endmodule
